// File: rtl/wav_clk_sw_pkg.sv
// Shared types and defaults for the glitch-free clock-switch sequencer.
package wav_clk_sw_pkg;

    // Sequencer phases, in the order a switch walks through them.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GATE_OFF = 3'd1,
        SWITCH   = 3'd2,
        GATE_ON  = 3'd3,
        DONE     = 3'd4
    } state_e;

    // Default dwell times (in clk cycles) and the counter width that holds them.
    localparam int unsigned DEFAULT_GATE_WAIT = 4;
    localparam int unsigned DEFAULT_MUX_WAIT  = 8;
    localparam int unsigned DEFAULT_CNT_W     = 4;

endpackage

// File: rtl/demet_reset.sv
// Two-flop synchronizer with asynchronous active-high reset to 0.
// Brings the register-block select request into the clk domain.
module demet_reset (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next values: shift the asynchronous input through the two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops; both clear to 0 on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/wav_clock_switch_seq.sv
// Glitch-free sequencer driving the 2:1 clock mux select. A synchronized
// request starts a timed gate-off / switch / gate-on walk so neither source
// clock reaches the mux output while its select changes.
module wav_clock_switch_seq
    import wav_clk_sw_pkg::*;
#(
    parameter logic        RESET_SEL = 1'b0,
    parameter int unsigned GATE_WAIT = DEFAULT_GATE_WAIT,
    parameter int unsigned MUX_WAIT  = DEFAULT_MUX_WAIT,
    parameter int unsigned CNT_W     = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic sel_req,
    input  logic sw_en,
    output logic mux_sel,
    output logic clk0_en,
    output logic clk1_en,
    output logic switch_busy,
    output logic switch_done
);

    // Both wait times must be nonzero and their reload value must fit the counter.
    if ((GATE_WAIT < 1) || (MUX_WAIT < 1) ||
        (GATE_WAIT > (1 << CNT_W)) || (MUX_WAIT > (1 << CNT_W))) begin : g_param_check
        $error("wav_clock_switch_seq: GATE_WAIT/MUX_WAIT must be >=1 and fit in CNT_W");
    end

    localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_WAIT - 1);
    localparam logic [CNT_W-1:0] MUX_LOAD  = CNT_W'(MUX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             target_q, target_d;
    logic             mux_sel_q, mux_sel_d;
    logic             clk0_en_q, clk0_en_d;
    logic             clk1_en_q, clk1_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             req_s;

    demet_reset u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sel_req),
        .q     (req_s)
    );

    // Next-state, dwell counter and registered-output values for the switch walk.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        mux_sel_d = mux_sel_q;
        clk0_en_d = clk0_en_q;
        clk1_en_d = clk1_en_q;
        case (state_q)
            IDLE: begin
                // Target is captured here and held until the walk returns to IDLE.
                if (sw_en && (req_s != mux_sel_q)) begin
                    state_d   = GATE_OFF;
                    target_d  = req_s;
                    cnt_d     = GATE_LOAD;
                    clk0_en_d = 1'b0;
                    clk1_en_d = 1'b0;
                end
            end
            GATE_OFF: begin
                if (cnt_q == '0) begin
                    state_d   = SWITCH;
                    mux_sel_d = target_q;
                    cnt_d     = MUX_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            SWITCH: begin
                if (cnt_q == '0) begin
                    state_d   = GATE_ON;
                    cnt_d     = GATE_LOAD;
                    clk0_en_d = ~target_q;
                    clk1_en_d = target_q;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            GATE_ON: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Status flags are registered copies of the state being entered.
        busy_d = (state_d == GATE_OFF) || (state_d == SWITCH) || (state_d == GATE_ON);
        done_d = (state_d == DONE);
    end

    // State, counter and output registers; reset forces the idle configuration at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            target_q  <= RESET_SEL;
            mux_sel_q <= RESET_SEL;
            clk0_en_q <= ~RESET_SEL;
            clk1_en_q <= RESET_SEL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            target_q  <= target_d;
            mux_sel_q <= mux_sel_d;
            clk0_en_q <= clk0_en_d;
            clk1_en_q <= clk1_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign mux_sel     = mux_sel_q;
    assign clk0_en     = clk0_en_q;
    assign clk1_en     = clk1_en_q;
    assign switch_busy = busy_q;
    assign switch_done = done_q;

endmodule

// File: tb/tb_wav_clock_switch_seq.sv
// Bench for wav_clock_switch_seq: directed scenarios with literal expectations
// plus a cycle-by-cycle comparison against a timeline model of a switch.
module tb_wav_clock_switch_seq;

    localparam int GW = 4;
    localparam int MW = 8;
    localparam int L  = 2 * GW + MW;   // offset of the done cycle from gate-off entry

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic sel_req = 1'b0;
    logic sw_en   = 1'b0;
    logic mux_sel, clk0_en, clk1_en, switch_busy, switch_done;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wav_clock_switch_seq #(
        .RESET_SEL (1'b0),
        .GATE_WAIT (GW),
        .MUX_WAIT  (MW),
        .CNT_W     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sel_req     (sel_req),
        .sw_en       (sw_en),
        .mux_sel     (mux_sel),
        .clk0_en     (clk0_en),
        .clk1_en     (clk1_en),
        .switch_busy (switch_busy),
        .switch_done (switch_done)
    );

    // {mux_sel, clk0_en, clk1_en, busy, done}
    function automatic logic [4:0] dut_vec();
        return {mux_sel, clk0_en, clk1_en, switch_busy, switch_done};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until bit idx of the output vector is 1.
    task automatic wait_bit(input int idx, input int max, output bit ok);
        logic [4:0] v;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            step();
            v = dut_vec();
            if (v[idx] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Timeline model: a switch begins at the edge where an idle sequencer sees an
    // enabled mismatch between the 2-cycle-delayed request and the current select;
    // every output afterwards is a function of the offset from that edge.
    int         m_n   = 0;
    int         m_e   = 0;
    bit         m_act = 1'b0;
    bit         m_tgt = 1'b0;
    bit         m_cur = 1'b0;
    bit         h0    = 1'b0;
    bit         h1    = 1'b0;
    logic [4:0] m_vec = 5'b01000;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act = 1'b0;
            m_cur = 1'b0;
            h0    = 1'b0;
            h1    = 1'b0;
            m_vec = 5'b01000;
        end else begin : model_step
            int k;
            bit idle_b, mx, e0, e1;
            m_n++;
            idle_b = !m_act || (m_n - 1 - m_e >= L + 1);
            if (idle_b && sw_en && (h1 != m_cur)) begin
                m_act = 1'b1;
                m_e   = m_n;
                m_tgt = h1;
            end
            h1 = h0;
            h0 = sel_req;
            k  = m_n - m_e;
            if (m_act && k <= L) begin
                mx    = (k >= GW) ? m_tgt : !m_tgt;
                m_cur = mx;
                e0    = (k >= GW + MW) ? !m_tgt : 1'b0;
                e1    = (k >= GW + MW) ? m_tgt : 1'b0;
                m_vec = {mx, e0, e1, (k < L), (k == L)};
            end else begin
                m_vec = {m_cur, !m_cur, m_cur, 2'b00};
            end
        end
    end

    // Per-cycle compare against the model plus the safety invariants.
    bit   pv = 1'b0;
    logic pmux, pen0, pen1, pdone;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pv = 1'b0;
        end else begin
            #1;
            if (!reset) begin
                chk("model_vec", dut_vec(), m_vec);
                chk("enables_exclusive", clk0_en & clk1_en, 0);
                if (pv) begin
                    if (mux_sel !== pmux)
                        chk("mux_change_gated", {pen0, pen1, clk0_en, clk1_en}, 0);
                    chk("done_single_pulse", pdone & switch_done, 0);
                end
                pv    = 1'b1;
                pmux  = mux_sel;
                pen0  = clk0_en;
                pen1  = clk1_en;
                pdone = switch_done;
            end
        end
    end

    initial begin
        int  t_fall, t_mux, t_en1, t_done, busy_cnt, zero_cnt;
        bit  ok, changed;

        // Reset state, held for the whole reset window.
        repeat (3) @(posedge clk);
        #1 chk("reset_vec_a", dut_vec(), 5'b01000);
        step();
        step();
        chk("reset_vec_b", dut_vec(), 5'b01000);
        @(negedge clk);
        reset = 1'b0;
        sw_en = 1'b1;
        step(); step(); step();
        chk("post_reset_idle", dut_vec(), 5'b01000);

        // Basic 0->1 switch timeline.
        @(negedge clk);
        sel_req  = 1'b1;
        t_fall   = -1; t_mux = -1; t_en1 = -1; t_done = -1;
        busy_cnt = 0;  zero_cnt = 0;
        for (int i = 1; i <= 25; i++) begin
            step();
            if (t_fall < 0 && clk0_en === 1'b0) t_fall = i;
            if (t_mux  < 0 && mux_sel === 1'b1) t_mux  = i;
            if (t_en1  < 0 && clk1_en === 1'b1) t_en1  = i;
            if (t_done < 0 && switch_done === 1'b1) t_done = i;
            if (switch_busy === 1'b1) busy_cnt++;
            if (clk0_en === 1'b0 && clk1_en === 1'b0) zero_cnt++;
        end
        chk("t2_clk0_fall_lat", t_fall, 3);
        chk("t2_mux_after_fall", t_mux - t_fall, 4);
        chk("t2_en1_after_mux", t_en1 - t_mux, 8);
        chk("t2_done_after_en1", t_done - t_en1, 4);
        chk("t2_busy_cycles", busy_cnt, 16);
        chk("t2_both_off_cycles", zero_cnt, 12);
        chk("t2_final_vec", dut_vec(), 5'b10100);

        // Return to clk0, then a request withdrawn during SWITCH.
        @(negedge clk);
        sel_req = 1'b0;
        wait_bit(0, 40, ok);
        chk("t3_reverse_done", ok, 1);
        step(); step();
        @(negedge clk);
        sel_req = 1'b1;
        wait_bit(4, 40, ok);
        chk("t3_reach_switch", ok, 1);
        @(negedge clk);
        sel_req = 1'b0;
        wait_bit(0, 40, ok);
        chk("t3_first_done", ok, 1);
        chk("t3_first_done_vec", dut_vec(), 5'b10101);
        wait_bit(0, 40, ok);
        chk("t3_second_done", ok, 1);
        chk("t3_second_done_vec", dut_vec(), 5'b01001);
        step();
        chk("t3_back_idle", dut_vec(), 5'b01000);

        // Switching disabled: request held, nothing moves.
        @(negedge clk);
        sw_en   = 1'b0;
        sel_req = 1'b1;
        changed = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (dut_vec() !== 5'b01000) changed = 1'b1;
        end
        chk("t4_hold_while_disabled", changed, 0);
        @(negedge clk);
        sw_en = 1'b1;
        step();
        chk("t4_start_one_cycle", dut_vec(), 5'b00010);

        // Asynchronous reset in GATE_ON, then a fresh full sequence.
        wait_bit(2, 40, ok);
        chk("t5_reach_gate_on", ok, 1);
        #2 reset = 1'b1;
        #1 chk("t5_async_reset_vec", dut_vec(), 5'b01000);
        @(negedge clk);
        reset = 1'b0;
        wait_bit(0, 40, ok);
        chk("t5_new_seq_done", ok, 1);
        chk("t5_new_seq_vec", dut_vec(), 5'b10101);

        // Random request / enable traffic; model and invariants check every cycle.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) sel_req = ~sel_req;
            sw_en = ($urandom_range(0, 9) != 0);
        end
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
